univ_async_fifo: RTL and testbench
==================================

UNIV_ASYNC_FIFO -- requirements
Module: univ_async_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: number of entries; SHALL be a power of two, at least 2.
REQ-002 Parameter DATA_WIDTH, default 32: width of one entry in bits.
REQ-003 wclk  input  1  the single clock; all state SHALL update on its rising edge only.
REQ-004 wrst  input  1  reset; synchronous and active-high.
REQ-005 w_en  input  1  write request for the current cycle.
REQ-006 r_en  input  1  read request for the current cycle.
REQ-007 data_in  input  DATA_WIDTH  write data, sampled when a write is accepted.
REQ-008 data_out  output  DATA_WIDTH  registered read data.
REQ-009 full  output  1  high when FIFO_DEPTH entries are stored.
REQ-010 empty  output  1  high when zero entries are stored.
REQ-011 One clock; reset is synchronous and active-high. There are no separate read-clock or read-reset ports.

Function
REQ-012 Storage SHALL be a FIFO_DEPTH x DATA_WIDTH array, addressed by a write pointer and a read pointer.
REQ-013 Each pointer SHALL be clog2(FIFO_DEPTH)+1 bits wide, binary, and wrap modulo 2*FIFO_DEPTH; the low bits address the array.
REQ-014 A write SHALL be accepted at a rising edge when w_en=1 and full=0: mem[wptr] <= data_in and wptr increments.
REQ-015 A read SHALL be accepted at a rising edge when r_en=1 and empty=0: data_out <= mem[rptr] and rptr increments.
REQ-016 When no read is accepted, data_out SHALL hold its previous value.
REQ-017 empty SHALL be high exactly when wptr equals rptr.
REQ-018 full SHALL be high exactly when the pointers' MSBs differ and all other pointer bits are equal.
REQ-019 full and empty SHALL be combinational decodes of the registered pointers, so they change in the cycle after the causing edge.
REQ-020 A write while full SHALL be dropped: no pointer change, no memory change, no error output.
REQ-021 A read while empty SHALL be ignored: data_out holds and the pointers do not change.
REQ-022 Write-to-read latency: a word written at edge N SHALL be readable at edge N+1, because empty is low after edge N.
REQ-023 Simultaneous w_en and r_en when neither full nor empty: both SHALL be accepted and the occupancy SHALL be unchanged.
REQ-024 Simultaneous w_en and r_en when full: only the read SHALL be accepted.
REQ-025 Simultaneous w_en and r_en when empty: only the write SHALL be accepted.
REQ-026 Data SHALL leave in strict write order; occupancy SHALL never exceed FIFO_DEPTH, including across pointer wrap-around.

Reset
REQ-027 While wrst=1 at a rising edge: wptr=0, rptr=0, data_out=0; hence empty=1 and full=0 from the next cycle.
REQ-028 Reset SHALL override any concurrent w_en or r_en.
REQ-029 Reset mid-operation SHALL discard all stored entries; memory contents need not be cleared.

Structure
REQ-030 A shared package SHALL hold the default FIFO_DEPTH and DATA_WIDTH constants and the pointer-width function (clog2+1).
REQ-031 The storage array SHALL be one sub-module, fifo_mem: synchronous write, read address driven from rptr.
REQ-032 Pointer, flag and output-register logic SHALL live in univ_async_fifo.

Verification
REQ-033 Reset, then write 1, 10, 100, then three reads -> data_out = 1, 10, 100 in order; empty=1 afterwards.
REQ-034 For i=0..7: write 2**i, then read -> data_out = 2**i each time; full never asserts.
REQ-035 Nine consecutive writes of 2**i (i=0..8) -> full=1 after the 8th write; 256 is dropped; eight reads return 1,2,4,...,128; empty=1 at the end.
REQ-036 Read with empty=1 after data_out=128 -> data_out stays 128 and empty stays 1.
REQ-037 Fill to full, then assert w_en and r_en together with data_in=0xAA -> one entry is read out, 0xAA is not stored, and full deasserts.
REQ-038 Write 3 words, assert wrst for one cycle -> empty=1, full=0, data_out=0, and the next write/read returns the new value.

Source files
------------

// File: rtl/univ_async_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO: default geometry and
// the pointer-width function used by both the top level and the storage array.
package univ_async_fifo_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // One extra bit beyond the address lets equal addresses be told apart as full or empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write port, combinational read port addressed
// by the read pointer so the top level can register the selected word.
module fifo_mem
    import univ_async_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = DEFAULT_DATA_WIDTH,
    parameter int AW    = ptr_width(DEFAULT_FIFO_DEPTH) - 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/univ_async_fifo.sv
// Single-clock FIFO with binary wrap-around pointers, combinational full/empty
// decode and a registered read-data output.
module univ_async_fifo
    import univ_async_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rd_data;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign wr_accept = w_en && !full;
    assign rd_accept = r_en && !empty;

    // Reset wins over a concurrent write, so the array is never touched during reset.
    assign mem_we = wr_accept && !wrst;

    fifo_mem #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk   (wclk),
        .we    (mem_we),
        .waddr (wptr[AW-1:0]),
        .wdata (data_in),
        .raddr (rptr[AW-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wptr     <= '0;
            rptr     <= '0;
            data_out <= '0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_accept) begin
                rptr     <= rptr + PTR_ONE;
                data_out <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_univ_async_fifo.sv
// Directed self-checking bench for univ_async_fifo at the default 8 x 32 geometry,
// with every expected value worked out by hand.
module tb_univ_async_fifo;

    logic        wclk;
    logic        wrst;
    logic        w_en;
    logic        r_en;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;

    univ_async_fifo #(
        .FIFO_DEPTH (8),
        .DATA_WIDTH (32)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .w_en     (w_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Drive one cycle of inputs at the falling edge, then settle just past the rising edge.
    task automatic applyStimulus(input logic rst_v, input logic we_v, input logic re_v,
                                 input logic [31:0] din_v);
        @(negedge wclk);
        wrst    = rst_v;
        w_en    = we_v;
        r_en    = re_v;
        data_in = din_v;
        @(posedge wclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            $error("[TB] check %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        wrst    = 1'b1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;

        // Reset held for two cycles while a write and read are also requested.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hDEAD);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hBEEF);
        checkOutput("reset_empty", {31'd0, empty}, 32'd1);
        checkOutput("reset_full", {31'd0, full}, 32'd0);
        checkOutput("reset_data_out", data_out, 32'd0);

        // Three writes then three reads in order.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd1);
        checkOutput("first_write_not_empty", {31'd0, empty}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd10);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd100);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        checkOutput("order_read0", data_out, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        checkOutput("order_read1", data_out, 32'd10);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        checkOutput("order_read2", data_out, 32'd100);
        checkOutput("order_empty_after", {31'd0, empty}, 32'd1);

        // Walking one, single write then single read each time.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd1 << i);
            checkOutput($sformatf("walk_full_%0d", i), {31'd0, full}, 32'd0);
            applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
            checkOutput($sformatf("walk_data_%0d", i), data_out, 32'd1 << i);
        end

        // Nine writes: the ninth arrives while full and must be dropped.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd1 << i);
            if (i == 6) checkOutput("fill_not_full_7", {31'd0, full}, 32'd0);
            if (i == 7) checkOutput("fill_full_8", {31'd0, full}, 32'd1);
        end
        checkOutput("fill_full_after_drop", {31'd0, full}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
            checkOutput($sformatf("drain_data_%0d", i), data_out, 32'd1 << i);
        end
        checkOutput("drain_empty", {31'd0, empty}, 32'd1);

        // Read while empty leaves data_out and empty untouched.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        checkOutput("underflow_data_hold", data_out, 32'd128);
        checkOutput("underflow_empty", {31'd0, empty}, 32'd1);

        // Fill, then write+read together while full: only the read happens.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h10 + i);
        end
        checkOutput("full_before_wr_rd", {31'd0, full}, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hAA);
        checkOutput("full_wr_rd_data", data_out, 32'h10);
        checkOutput("full_wr_rd_full", {31'd0, full}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
            checkOutput($sformatf("full_rest_%0d", i), data_out, 32'h10 + i);
        end
        checkOutput("full_aa_not_stored", {31'd0, empty}, 32'd1);

        // Reset with data stored discards it.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd5);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd6);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd7);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("midreset_empty", {31'd0, empty}, 32'd1);
        checkOutput("midreset_full", {31'd0, full}, 32'd0);
        checkOutput("midreset_data_out", data_out, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h1234);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        checkOutput("midreset_new_value", data_out, 32'h1234);
        checkOutput("midreset_empty_after", {31'd0, empty}, 32'd1);

        // Write+read together while empty: only the write happens.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h55);
        checkOutput("empty_wr_rd_data_hold", data_out, 32'h1234);
        checkOutput("empty_wr_rd_not_empty", {31'd0, empty}, 32'd0);

        // Write+read together mid-range: both happen, occupancy stays at two.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h66);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h77);
        checkOutput("mid_wr_rd_data", data_out, 32'h55);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        checkOutput("mid_read_66", data_out, 32'h66);
        checkOutput("mid_one_left", {31'd0, empty}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        checkOutput("mid_read_77", data_out, 32'h77);
        checkOutput("mid_empty_end", {31'd0, empty}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
